// File: rtl/path_pkg.sv
// Shared types and constants for the path-planner datapath (sender and receiver).
package path_pkg;

    localparam int NODE_WIDTH_DEF   = 8;
    localparam int MAX_PATH_LEN_DEF = 64;
    localparam logic [NODE_WIDTH_DEF-1:0] NO_PRED = '1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WALK_REQ  = 3'd1,
        ST_WALK_WAIT = 3'd2,
        ST_SEND      = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/path_sender_if.sv
// Valid/ready node stream from the path sender to the output link.
interface path_sender_if #(
    parameter int NODE_WIDTH = 8
);
    logic                  tx_valid;
    logic                  tx_ready;
    logic [NODE_WIDTH-1:0] tx_data;
    logic                  tx_last;

    modport master (output tx_valid, output tx_data, output tx_last, input tx_ready);
    modport slave  (input tx_valid, input tx_data, input tx_last, output tx_ready);
endinterface

// File: rtl/path_lifo.sv
// Path buffer: registered storage, combinational top-of-stack, synchronous clear.
module path_lifo
    import path_pkg::*;
#(
    parameter int WIDTH     = NODE_WIDTH_DEF,
    parameter int DEPTH     = MAX_PATH_LEN_DEF,
    parameter int PTR_WIDTH = ptr_width(MAX_PATH_LEN_DEF)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 clear,
    input  logic [WIDTH-1:0]     din,
    output logic [WIDTH-1:0]     dout,
    output logic                 full,
    output logic                 empty,
    output logic [PTR_WIDTH-1:0] count
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [PTR_WIDTH-1:0] sp_q, sp_d;
    logic [IDX_W-1:0]     wr_idx;
    logic [IDX_W-1:0]     rd_idx;

    assign wr_idx = sp_q[IDX_W-1:0];
    assign rd_idx = IDX_W'(sp_q - PTR_WIDTH'(1));
    assign full   = (sp_q == PTR_WIDTH'(DEPTH));
    assign empty  = (sp_q == '0);
    assign count  = sp_q;
    assign dout   = mem_q[rd_idx];

    always_comb begin
        sp_d = sp_q;
        if (clear) begin
            sp_d = '0;
        end else if (push) begin
            sp_d = sp_q + PTR_WIDTH'(1);
        end else if (pop) begin
            sp_d = sp_q - PTR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_q[wr_idx] <= din;
        end
    end

    // The walker checks full before pushing and SEND pops only a non-empty stack.
    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full && !clear));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty && !clear));

endmodule

// File: rtl/path_sender.sv
// Walks the predecessor chain destino->fonte into a LIFO, then streams it fonte-first.
module path_sender
    import path_pkg::*;
#(
    parameter int NODE_WIDTH   = NODE_WIDTH_DEF,
    parameter int MAX_PATH_LEN = MAX_PATH_LEN_DEF,
    parameter int PTR_WIDTH    = ptr_width(MAX_PATH_LEN_DEF)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NODE_WIDTH-1:0] fonte,
    input  logic [NODE_WIDTH-1:0] destino,
    output logic                  pred_rd_en,
    output logic [NODE_WIDTH-1:0] pred_addr,
    input  logic [NODE_WIDTH-1:0] pred_data,
    path_sender_if.master         tx,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [NODE_WIDTH-1:0] NoPred = '1;

    state_t                state_q, state_d;
    logic [NODE_WIDTH-1:0] cur_q, cur_d;
    logic [NODE_WIDTH-1:0] fonte_q, fonte_d;
    logic                  error_q, error_d;

    logic                  lifo_push, lifo_pop, lifo_clear;
    logic [NODE_WIDTH-1:0] lifo_din, lifo_dout;
    logic                  lifo_full, lifo_empty;
    logic [PTR_WIDTH-1:0]  lifo_count;

    logic                  send_valid;
    logic [NODE_WIDTH-1:0] send_data;
    logic                  send_last;

    path_lifo #(
        .WIDTH    (NODE_WIDTH),
        .DEPTH    (MAX_PATH_LEN),
        .PTR_WIDTH(PTR_WIDTH)
    ) u_lifo (
        .clk  (clk),
        .rst  (rst),
        .push (lifo_push),
        .pop  (lifo_pop),
        .clear(lifo_clear),
        .din  (lifo_din),
        .dout (lifo_dout),
        .full (lifo_full),
        .empty(lifo_empty),
        .count(lifo_count)
    );

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        fonte_d    = fonte_q;
        error_d    = error_q;
        lifo_push  = 1'b0;
        lifo_pop   = 1'b0;
        lifo_clear = 1'b0;
        lifo_din   = pred_data;
        pred_rd_en = 1'b0;
        pred_addr  = '0;
        send_valid = 1'b0;
        send_data  = '0;
        send_last  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    fonte_d   = fonte;
                    cur_d     = destino;
                    error_d   = 1'b0;
                    lifo_push = 1'b1;
                    lifo_din  = destino;
                    state_d   = (destino == fonte) ? ST_SEND : ST_WALK_REQ;
                end
            end
            ST_WALK_REQ: begin
                pred_rd_en = 1'b1;
                pred_addr  = cur_q;
                state_d    = ST_WALK_WAIT;
            end
            ST_WALK_WAIT: begin
                // Missing predecessor wins over a full stack; a loop ends on full.
                if (pred_data == NoPred || lifo_full) begin
                    error_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    lifo_push = 1'b1;
                    if (pred_data == fonte_q) begin
                        state_d = ST_SEND;
                    end else begin
                        cur_d   = pred_data;
                        state_d = ST_WALK_REQ;
                    end
                end
            end
            ST_SEND: begin
                send_valid = 1'b1;
                send_data  = lifo_dout;
                send_last  = (lifo_count == PTR_WIDTH'(1));
                if (tx.tx_ready && !lifo_empty) begin
                    lifo_pop = 1'b1;
                    if (send_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                lifo_clear = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            fonte_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            fonte_q <= fonte_d;
            error_q <= error_d;
        end
    end

    assign tx.tx_valid = send_valid;
    assign tx.tx_data  = send_data;
    assign tx.tx_last  = send_last;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign error       = error_q;

endmodule
